updown_monitor: RTL and testbench
=================================

Name: updown_monitor

Overview:
- Receive-side counterpart to the board's up/down counter.
- Samples a WIDTH-bit count stream and infers the count direction from successive samples: +1 is up, -1 is down, modulo 2^WIDTH.
- Flags illegal steps and counts consecutive same-direction steps.
- Drives one 7-segment digit with 'U', 'd', '-' or 'E', so the counter's direction can be checked on a second board or in loopback.

Parameters:
- WIDTH, 4, bit width of the sampled count.
- RUN_W, 8, width of the run-length counter.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clock  input  1  system clock, all state changes on posedge.
- reset  input  1  synchronous, active-low; clock clock.
- sample_in  input  WIDTH  count value from the counter under observation.
- sample_valid  input  1  sample_in is taken on a rising edge only when this is 1.
- dir_up  output  1  1 = last legal step was +1, 0 = -1 or no direction yet.
- dir_valid  output  1  1 while in TRACK_UP or TRACK_DOWN.
- step_err  output  1  one-cycle pulse for each illegal step.
- err_cnt  output  ERR_W  number of illegal steps since reset, saturating.
- run_len  output  RUN_W  consecutive legal steps in the current direction, saturating.
- seg  output  7  active-low segments, seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, constant 1 (off).
- digit_en  output  1  constant 1.

Behaviour:
- All outputs registered. One-cycle latency: a sample accepted at edge N is reflected in the outputs after edge N.
- reset=0 at an edge forces these values, and overrides sample_valid in that cycle (a reset mid-run drops the held sample):
  - state=IDLE, prev=0, have_prev=0
  - dir_up=0, dir_valid=0, step_err=0
  - err_cnt=0, run_len=0
  - seg=7'b0111111 ('-', only g lit)
- sample_valid=0: all state holds; step_err=0.
- Step classification on an accepted sample s, with d = (s - prev) mod 2^WIDTH:
  - d=1 → UP; this includes wrap 2^WIDTH-1 → 0.
  - d=2^WIDTH-1 → DOWN; this includes wrap 0 → 2^WIDTH-1.
  - d=0 → HOLD.
  - anything else → ILLEGAL.
- prev <= s on every accepted sample; have_prev <= 1.
- States and transitions:
  - IDLE: the first accepted sample only loads prev, with no classification. With have_prev=1, transitions are as in TRACK_UP/TRACK_DOWN.
  - TRACK_UP, TRACK_DOWN, ERROR, on an accepted sample:
    - UP: next state TRACK_UP. run_len = run_len+1 if already TRACK_UP, else 1.
    - DOWN: next state TRACK_DOWN. run_len = run_len+1 if already TRACK_DOWN, else 1.
    - HOLD: state and run_len unchanged; not an error.
    - ILLEGAL: next state ERROR; run_len=0; step_err=1 for one cycle; err_cnt += 1, saturating at 2^ERR_W-1.
  - IDLE (have_prev=1) remains until the first UP/DOWN/ILLEGAL step.
- run_len saturates at 2^RUN_W-1 and does not wrap.
- dir_up=1 only in TRACK_UP. dir_valid=1 in TRACK_UP/TRACK_DOWN; 0 in IDLE/ERROR.
- dir_up holds its last value in ERROR. It stays 0 there only if no UP step ever occurred.
- Segment patterns:
  - IDLE '-': 7'b0111111
  - TRACK_UP 'U' (b,c,d,e,f lit): 7'b1000001
  - TRACK_DOWN 'd' (b,c,d,e,g lit): 7'b0100001
  - ERROR 'E' (a,d,e,f,g lit): 7'b0000110
- A single illegal step followed by a legal step recovers directly to TRACK_UP/TRACK_DOWN; err_cnt is retained.

Test Plan:
- Reset: hold reset=0 for 2 cycles with sample_valid=1 → state IDLE, seg=7'b0111111, err_cnt=0, run_len=0, no step_err.
- Up run with wrap: samples 13,14,15,0,1 on consecutive cycles:
  - after the sample 14 edge: dir_up=1, dir_valid=1, seg=7'b1000001.
  - final run_len=4, step_err never asserted.
- Down run with wrap: samples 2,1,0,15 → dir_up=0, dir_valid=1, seg=7'b0100001, run_len=3.
- Direction reversal and hold: samples 5,6,7,7,6:
  - after 7,7: run_len=2, still TRACK_UP.
  - after the final 6: TRACK_DOWN, run_len=1.
- Illegal step then recovery: samples 3,4,9,10:
  - after 9: step_err=1 for exactly one cycle, err_cnt=1, seg=7'b0000110, dir_valid=0, run_len=0.
  - after 10: TRACK_UP, run_len=1, err_cnt stays 1.
- Gating and saturation:
  - sample_valid=0 between samples leaves all outputs unchanged.
  - 16 consecutive illegal jumps (0,8,0,8,…) → err_cnt saturates at 15.
  - Mid-run reset → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/updown_monitor.sv
// Receive-side monitor for an up/down counter stream: infers step direction,
// flags illegal steps, tracks run length and shows U/d/-/E on one 7-seg digit.
module updown_monitor #(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             dir_up,
    output logic             dir_valid,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [RUN_W-1:0] run_len,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             digit_en
);

    typedef enum logic [1:0] {IDLE, TRACK_UP, TRACK_DOWN, ERROR} state_t;
    typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_ILLEGAL} step_t;

    localparam logic [6:0]       SEG_DASH = 7'b0111111;
    localparam logic [6:0]       SEG_U    = 7'b1000001;
    localparam logic [6:0]       SEG_D    = 7'b0100001;
    localparam logic [6:0]       SEG_E    = 7'b0000110;
    localparam logic [WIDTH-1:0] DIFF_UP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIFF_DN  = '1;
    localparam logic [WIDTH-1:0] DIFF_0   = '0;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state, state_next;
    step_t            step;
    logic [WIDTH-1:0] prev, prev_next, diff;
    logic             have_prev, have_prev_next;
    logic             dir_up_next, step_err_next;
    logic [ERR_W-1:0] err_cnt_next;
    logic [RUN_W-1:0] run_len_next;
    logic [6:0]       seg_next;

    // Modulo-2^WIDTH difference makes the wrap cases fall out naturally.
    always_comb begin
        diff = sample_in - prev;
        if (diff == DIFF_UP)     step = STEP_UP;
        else if (diff == DIFF_DN) step = STEP_DOWN;
        else if (diff == DIFF_0)  step = STEP_HOLD;
        else                      step = STEP_ILLEGAL;
    end

    // NOTE: every signal gets a hold/default value first so no path infers a latch.
    always_comb begin
        state_next     = state;
        prev_next      = prev;
        have_prev_next = have_prev;
        dir_up_next    = dir_up;
        step_err_next  = 1'b0;
        err_cnt_next   = err_cnt;
        run_len_next   = run_len;

        if (sample_valid) begin
            prev_next      = sample_in;
            have_prev_next = 1'b1;
            if (have_prev) begin
                case (step)
                    STEP_UP: begin
                        state_next  = TRACK_UP;
                        dir_up_next = 1'b1;
                        if (state != TRACK_UP)     run_len_next = RUN_ONE;
                        else if (run_len != RUN_MAX) run_len_next = run_len + RUN_ONE;
                    end
                    STEP_DOWN: begin
                        state_next  = TRACK_DOWN;
                        dir_up_next = 1'b0;
                        if (state != TRACK_DOWN)   run_len_next = RUN_ONE;
                        else if (run_len != RUN_MAX) run_len_next = run_len + RUN_ONE;
                    end
                    STEP_ILLEGAL: begin
                        state_next    = ERROR;
                        run_len_next  = '0;
                        step_err_next = 1'b1;
                        if (err_cnt != ERR_MAX) err_cnt_next = err_cnt + ERR_ONE;
                    end
                    default: ;
                endcase
            end
        end

        case (state_next)
            TRACK_UP:   seg_next = SEG_U;
            TRACK_DOWN: seg_next = SEG_D;
            ERROR:      seg_next = SEG_E;
            default:    seg_next = SEG_DASH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            prev      <= '0;
            have_prev <= 1'b0;
            dir_up    <= 1'b0;
            dir_valid <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
            run_len   <= '0;
            seg       <= SEG_DASH;
        end else begin
            state     <= state_next;
            prev      <= prev_next;
            have_prev <= have_prev_next;
            dir_up    <= dir_up_next;
            dir_valid <= (state_next == TRACK_UP) || (state_next == TRACK_DOWN);
            step_err  <= step_err_next;
            err_cnt   <= err_cnt_next;
            run_len   <= run_len_next;
            seg       <= seg_next;
        end
    end

    assign dp       = 1'b1;
    assign digit_en = 1'b1;

endmodule

// File: tb/tb_updown_monitor.sv
// Scoreboard bench for updown_monitor: the driver pushes model predictions,
// a monitor pops and compares them one time unit after each rising edge.
module tb_updown_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       dir_up, dir_valid, step_err, dp, digit_en;
    logic [3:0] err_cnt;
    logic [7:0] run_len;
    logic [6:0] seg;

    updown_monitor #(.WIDTH(4), .RUN_W(8), .ERR_W(4)) dut (
        .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .dir_up(dir_up), .dir_valid(dir_valid), .step_err(step_err), .err_cnt(err_cnt),
        .run_len(run_len), .seg(seg), .dp(dp), .digit_en(digit_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       dir_up;
        bit       dir_valid;
        bit       step_err;
        int       err_cnt;
        int       run_len;
        bit [6:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: direction as a signed step (+1/-1), 0 = none yet, 2 = error.
    int m_dir, m_prev, m_run, m_err;
    bit m_have, m_up, m_serr;

    function automatic bit [6:0] glyph(input int d);
        if (d == 1)       return 7'b1000001;
        else if (d == -1) return 7'b0100001;
        else if (d == 2)  return 7'b0000110;
        else              return 7'b0111111;
    endfunction

    task automatic model(input bit rst, input bit v, input int s);
        int d;
        m_serr = 0;
        if (!rst) begin
            m_dir = 0; m_prev = 0; m_have = 0; m_up = 0; m_run = 0; m_err = 0;
        end else if (v) begin
            if (m_have) begin
                d = (s - m_prev + 16) % 16;
                if (d == 1 || d == 15) begin
                    int sd = (d == 1) ? 1 : -1;
                    m_run = (m_dir == sd) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                    m_dir = sd;
                    m_up  = (sd == 1);
                end else if (d != 0) begin
                    m_dir = 2; m_run = 0; m_serr = 1;
                    m_err = (m_err < 15) ? m_err + 1 : 15;
                end
            end
            m_prev = s;
            m_have = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit rst, input bit v, input int s);
        exp_t e;
        @(negedge clock);
        reset        = rst;
        sample_valid = v;
        sample_in    = 4'(s);
        @(posedge clock);
        model(rst, v, s);
        e.dir_up    = m_up;
        e.dir_valid = (m_dir == 1 || m_dir == -1);
        e.step_err  = m_serr;
        e.err_cnt   = m_err;
        e.run_len   = m_run;
        e.seg       = glyph(m_dir);
        q.push_back(e);
    endtask

    task automatic run(input int vals[]);
        foreach (vals[i]) step(1, 1, vals[i]);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("dir_up",    int'(dir_up),    int'(e.dir_up));
                check("dir_valid", int'(dir_valid), int'(e.dir_valid));
                check("step_err",  int'(step_err),  int'(e.step_err));
                check("err_cnt",   int'(err_cnt),   e.err_cnt);
                check("run_len",   int'(run_len),   e.run_len);
                check("seg",       int'(seg),       int'(e.seg));
                check("dp",        int'(dp),        1);
                check("digit_en",  int'(digit_en),  1);
            end
        end
    end

    initial begin : driver
        int budget;
        // Reset held with sample_valid=1 must not load a sample.
        step(0, 1, 9);
        step(0, 1, 3);
        run('{13, 14, 15, 0, 1});
        step(0, 0, 0);
        run('{2, 1, 0, 15});
        run('{5, 6, 7, 7, 6});
        run('{3, 4, 9, 10});
        // Gated cycles between samples must not disturb anything.
        step(1, 0, 11);
        step(1, 1, 11);
        step(1, 0, 3);
        step(1, 0, 12);
        step(1, 1, 12);
        for (int i = 0; i < 18; i++) step(1, 1, (i % 2) * 8);
        // Mid-run reset, then run_len saturation on a long up run.
        run('{1, 2, 3});
        step(0, 1, 4);
        for (int i = 0; i < 300; i++) step(1, 1, i % 16);
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            int s;
            case ($urandom_range(0, 3))
                0: s = (m_prev + 1) % 16;
                1: s = (m_prev + 15) % 16;
                2: s = m_prev;
                default: s = $urandom_range(0, 15);
            endcase
            step(r >= 2, r < 80, s);
        end
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clock);
            budget++;
        end
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
